// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES datapath definitions for the ShiftRows/MixColumns
//                stage: state/byte/column widths, the GF(2^8) reduction
//                constant, xtime/gmul field arithmetic and the row-rotation
//                helpers used on a 128-bit column-major state.
//                Byte (r,c) of a state lives at bits [(15-(4c+r))*8 +: 8],
//                so s(0,0) is the most significant byte.
//  Config      : SHIFT_MIX_INV_EN adds the inverse row rotation helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int c_STATE_W = 128;
    localparam int c_BYTE_W  = 8;
    localparam int c_COL_W   = 32;
    localparam logic [7:0] c_REDUCE = 8'h1B;   // x^8 = x^4 + x^3 + x + 1

    typedef logic [c_STATE_W-1:0] state_t;
    typedef logic [c_COL_W-1:0]   column_t;
    typedef logic [c_BYTE_W-1:0]  byte_t;

    // Multiply by {02} in GF(2^8).
    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? c_REDUCE : 8'h00);
    endfunction

    // General GF(2^8) multiply; with a constant b the unused partial
    // products fold away, leaving a small XOR network.
    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t acc;
        p   = '0;
        acc = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ acc;
            end
            acc = xtime(acc);
        end
        return p;
    endfunction

    // Row r rotated left by r byte positions.
    function automatic state_t shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[(15 - (4 * c + r)) * c_BYTE_W +: c_BYTE_W] =
                    s[(15 - (4 * ((c + r) % 4) + r)) * c_BYTE_W +: c_BYTE_W];
            end
        end
        return o;
    endfunction

`ifdef SHIFT_MIX_INV_EN
    // Row r rotated right by r byte positions.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[(15 - (4 * c + r)) * c_BYTE_W +: c_BYTE_W] =
                    s[(15 - (4 * ((c - r + 4) % 4) + r)) * c_BYTE_W +: c_BYTE_W];
            end
        end
        return o;
    endfunction
`endif

endpackage : aes_pkg
`default_nettype wire

// File: rtl/mix_single_column.sv
`default_nettype none
// ============================================================================
//  Module      : mix_single_column
//  Description : MixColumns on a single 32-bit column (s0 in bits [31:24]).
//                Forward matrix rows are rotations of {02 03 01 01}; the
//                inverse matrix rows are rotations of {0e 0b 0d 09}.
//  Config      : SHIFT_MIX_INV_EN adds i_inv and the inverse matrix.
//  Ports       : i_col  - input column
//                i_inv  - select inverse matrix (SHIFT_MIX_INV_EN only)
//                o_col  - mixed column
//  Revision    : 1.0 - initial release
// ============================================================================
module mix_single_column
    import aes_pkg::*;
(
    input  logic [c_COL_W-1:0] i_col,
`ifdef SHIFT_MIX_INV_EN
    input  logic               i_inv,
`endif
    output logic [c_COL_W-1:0] o_col
);

    byte_t w_s   [4];
    byte_t w_fwd [4];
`ifdef SHIFT_MIX_INV_EN
    byte_t w_inv [4];
`endif
    byte_t w_res [4];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_row
            assign w_s[g] = i_col[c_COL_W - 1 - g * c_BYTE_W -: c_BYTE_W];

            // {03}*x is expressed as xtime(x)^x to keep the forward path shallow.
            assign w_fwd[g] = xtime(w_s[g])
                            ^ xtime(w_s[(g + 1) % 4]) ^ w_s[(g + 1) % 4]
                            ^ w_s[(g + 2) % 4]
                            ^ w_s[(g + 3) % 4];

`ifdef SHIFT_MIX_INV_EN
            assign w_inv[g] = gmul(w_s[g],           8'h0E)
                            ^ gmul(w_s[(g + 1) % 4], 8'h0B)
                            ^ gmul(w_s[(g + 2) % 4], 8'h0D)
                            ^ gmul(w_s[(g + 3) % 4], 8'h09);
            assign w_res[g] = i_inv ? w_inv[g] : w_fwd[g];
`else
            assign w_res[g] = w_fwd[g];
`endif

            assign o_col[c_COL_W - 1 - g * c_BYTE_W -: c_BYTE_W] = w_res[g];
        end
    endgenerate

endmodule : mix_single_column
`default_nettype wire

// File: rtl/shift_mix_stage.sv
`default_nettype none
// ============================================================================
//  Module      : shift_mix_stage
//  Description : AES round stage applying ShiftRows then MixColumns (MixColumns
//                skipped on the final round) behind a valid/ready handshake.
//                PIPE_STAGES=1 registers only the result; PIPE_STAGES=2 adds a
//                register between ShiftRows and MixColumns. Each stage holds a
//                valid bit and is ready when empty or when the stage after it
//                is ready, so full throughput is one state per cycle.
//  Config      : SHIFT_MIX_INV_EN adds in_inv, selecting
//                InvShiftRows(InvMixColumns(state)) for that operand.
//  Parameters  : PIPE_STAGES - 1 or 2 register stages
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                in_valid   - in_state valid
//                in_ready   - stage accepts in_state this cycle
//                in_state   - SubBytes output state (column-major)
//                in_last    - final round, MixColumns skipped
//                in_inv     - inverse operation (SHIFT_MIX_INV_EN only)
//                out_valid  - out_state valid
//                out_ready  - downstream accepts
//                out_state  - transformed state
//                out_last   - in_last carried with its state
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_mix_stage
    import aes_pkg::*;
#(
    parameter int PIPE_STAGES = 1
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [c_STATE_W-1:0] in_state,
    input  logic                 in_last,
`ifdef SHIFT_MIX_INV_EN
    input  logic                 in_inv,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [c_STATE_W-1:0] out_state,
    output logic                 out_last
);

    // Forward ops permute rows before mixing and inverse ops after it, so the
    // single set of column mixers always sits after the optional mid register.
    state_t w_pre_state;
`ifdef SHIFT_MIX_INV_EN
    assign w_pre_state = in_inv ? in_state : shift_rows(in_state);
`else
    assign w_pre_state = shift_rows(in_state);
`endif

    logic   r_out_valid;
    state_t r_out_state;
    logic   r_out_last;
    logic   w_out_ready;

    // Operand presented to the mixers (from the mid register or directly).
    logic   w_mix_valid;
    state_t w_mix_state;
    logic   w_mix_last;
`ifdef SHIFT_MIX_INV_EN
    logic   w_mix_inv;
`endif

    // Output register can take new data when empty or being drained now.
    assign w_out_ready = ~r_out_valid | out_ready;

    generate
        if (PIPE_STAGES == 2) begin : g_pipe2
            logic   r_mid_valid;
            state_t r_mid_state;
            logic   r_mid_last;
`ifdef SHIFT_MIX_INV_EN
            logic   r_mid_inv;
`endif
            logic   w_mid_ready;

            assign w_mid_ready = ~r_mid_valid | w_out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mid_valid <= 1'b0;
                    r_mid_state <= '0;
                    r_mid_last  <= 1'b0;
`ifdef SHIFT_MIX_INV_EN
                    r_mid_inv   <= 1'b0;
`endif
                end else if (w_mid_ready) begin
                    r_mid_valid <= in_valid;
                    if (in_valid) begin
                        r_mid_state <= w_pre_state;
                        r_mid_last  <= in_last;
`ifdef SHIFT_MIX_INV_EN
                        r_mid_inv   <= in_inv;
`endif
                    end
                end
            end

            assign in_ready    = w_mid_ready;
            assign w_mix_valid = r_mid_valid;
            assign w_mix_state = r_mid_state;
            assign w_mix_last  = r_mid_last;
`ifdef SHIFT_MIX_INV_EN
            assign w_mix_inv   = r_mid_inv;
`endif
        end else begin : g_pipe1
            assign in_ready    = w_out_ready;
            assign w_mix_valid = in_valid;
            assign w_mix_state = w_pre_state;
            assign w_mix_last  = in_last;
`ifdef SHIFT_MIX_INV_EN
            assign w_mix_inv   = in_inv;
`endif
        end
    endgenerate

    state_t w_mixed;

    genvar gc;
    generate
        for (gc = 0; gc < 4; gc++) begin : g_col
            mix_single_column u_mix (
                .i_col (w_mix_state[c_STATE_W - 1 - gc * c_COL_W -: c_COL_W]),
`ifdef SHIFT_MIX_INV_EN
                .i_inv (w_mix_inv),
`endif
                .o_col (w_mixed[c_STATE_W - 1 - gc * c_COL_W -: c_COL_W])
            );
        end
    endgenerate

    state_t w_post_mix;
    state_t w_result;

    assign w_post_mix = w_mix_last ? w_mix_state : w_mixed;
`ifdef SHIFT_MIX_INV_EN
    assign w_result = w_mix_inv ? inv_shift_rows(w_post_mix) : w_post_mix;
`else
    assign w_result = w_post_mix;
`endif

    // Data only loads with a valid operand so a stalled or idle output keeps
    // its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_state <= '0;
            r_out_last  <= 1'b0;
        end else if (w_out_ready) begin
            r_out_valid <= w_mix_valid;
            if (w_mix_valid) begin
                r_out_state <= w_result;
                r_out_last  <= w_mix_last;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_state = r_out_state;
    assign out_last  = r_out_last;

endmodule : shift_mix_stage
`default_nettype wire

// File: tb/tb_shift_mix_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_mix_stage
//  Description : Self-checking bench for shift_mix_stage. Instance 0 uses
//                PIPE_STAGES=1, instance 1 uses PIPE_STAGES=2. Expected
//                results come from a byte-matrix AES model with carry-less
//                GF(2^8) multiply and polynomial reduction; a queue per
//                instance tracks accepted operands in order.
//  Config      : SHIFT_MIX_INV_EN enables in_inv stimulus and inverse checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_mix_stage;

    localparam logic [127:0] c_V_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] c_V_MC  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] c_V_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`ifdef SHIFT_MIX_INV_EN
    localparam bit c_INV_EN = 1'b1;
`else
    localparam bit c_INV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [127:0] in_state  [2];
    logic         in_last   [2];
    logic         in_inv    [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [127:0] out_state [2];
    logic         out_last  [2];

    shift_mix_stage #(.PIPE_STAGES(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_state  (in_state[0]),
        .in_last   (in_last[0]),
`ifdef SHIFT_MIX_INV_EN
        .in_inv    (in_inv[0]),
`endif
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_state (out_state[0]),
        .out_last  (out_last[0])
    );

    shift_mix_stage #(.PIPE_STAGES(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_state  (in_state[1]),
        .in_last   (in_last[1]),
`ifdef SHIFT_MIX_INV_EN
        .in_inv    (in_inv[1]),
`endif
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_state (out_state[1]),
        .out_last  (out_last[1])
    );

    typedef struct {
        logic [127:0] st;
        logic         last;
        int           cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc   = 0;
    bit           lat_chk = 1'b0;
    bit           acc    [2];
    bit           hold_v [2];
    logic [127:0] hold_s [2];
    logic         hold_l [2];

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (15'(a) << i);
        end
        for (int k = 14; k >= 8; k--) begin
            if (p[k]) p = p ^ (15'h11B << (k - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [3:0][3:0][7:0] ref_mix(input logic [3:0][3:0][7:0] g,
                                                    input logic [3:0][7:0] coef);
        logic [3:0][3:0][7:0] o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[r][c] = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    o[r][c] = o[r][c] ^ ref_mul(coef[(k - r + 4) % 4], g[k][c]);
                end
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic last,
                                           input logic inv);
        logic [3:0][3:0][7:0] a;
        logic [3:0][3:0][7:0] b;
        logic [3:0][7:0]      coef;
        logic [127:0]         res;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                a[r][c] = s[127 - 8 * (4 * c + r) -: 8];
        if (!inv) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    b[r][c] = a[r][(c + r) % 4];
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
            if (!last) b = ref_mix(b, coef);
        end else begin
            coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
            if (!last) a = ref_mix(a, coef);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    b[r][c] = a[r][(c - r + 4) % 4];
        end
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[127 - 8 * (4 * c + r) -: 8] = b[r][c];
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [127:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called at posedge+1 with inputs already driven; evaluates the coming
    // edge's transfers at posedge+2 and returns at the next posedge+1.
    task automatic tick();
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_t it;
            int   qs;
            qs = qsize(d);
            // Stage count equals how many states can be held in flight.
            chk($sformatf("in_ready[%0d]", d), in_ready[d], (qs < d + 1) || out_ready[d]);
            if (qs == 0) chk($sformatf("idle_valid[%0d]", d), out_valid[d], 1'b0);
            if (hold_v[d]) begin
                chk($sformatf("stall_valid[%0d]", d), out_valid[d], 1'b1);
                chk($sformatf("stall_state[%0d]", d), out_state[d], hold_s[d]);
                chk($sformatf("stall_last[%0d]", d),  out_last[d],  hold_l[d]);
            end
            hold_v[d] = (out_valid[d] === 1'b1) && !out_ready[d];
            hold_s[d] = out_state[d];
            hold_l[d] = out_last[d];
            if ((out_valid[d] === 1'b1) && out_ready[d] && qs > 0) begin
                if (d == 0) it = q0.pop_front();
                else        it = q1.pop_front();
                chk($sformatf("out_state[%0d]", d), out_state[d], it.st);
                chk($sformatf("out_last[%0d]", d),  out_last[d],  it.last);
                if (lat_chk) chk($sformatf("latency[%0d]", d), cyc - it.cyc, d + 1);
            end
            acc[d] = in_valid[d] && (in_ready[d] === 1'b1);
            if (acc[d]) begin
                it.st   = model(in_state[d], in_last[d], in_inv[d]);
                it.last = in_last[d];
                it.cyc  = cyc;
                if (d == 0) q0.push_back(it);
                else        q1.push_back(it);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic stream(input int d, input int n, input int vprob, input int rprob,
                          input int stall, input bit rand_inv, output int used);
        logic [127:0] st;
        logic         la;
        logic         iv;
        int           sent;
        int           g;
        sent = 0;
        g    = 0;
        st   = rnd();
        la   = ($urandom_range(1) != 0);
        iv   = rand_inv && ($urandom_range(1) != 0);
        while ((sent < n || qsize(d) != 0) && g < 4000) begin
            in_valid[d]  = (sent < n) && ($urandom_range(99) < vprob);
            in_state[d]  = st;
            in_last[d]   = la;
            in_inv[d]    = iv;
            out_ready[d] = (g < stall) ? 1'b0 : ($urandom_range(99) < rprob);
            tick();
            if (acc[d]) begin
                sent++;
                st = rnd();
                la = ($urandom_range(1) != 0);
                iv = rand_inv && ($urandom_range(1) != 0);
            end
            g++;
        end
        in_valid[d]  = 1'b0;
        in_inv[d]    = 1'b0;
        out_ready[d] = 1'b1;
        chk($sformatf("stream_done[%0d]", d), (g < 4000), 1'b1);
        used = g;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int used;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_state[d]  = '0;
            in_last[d]   = 1'b0;
            in_inv[d]    = 1'b0;
            out_ready[d] = 1'b1;
            hold_v[d]    = 1'b0;
            acc[d]       = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", out_valid[d], 1'b0);
            chk("rst_state", out_state[d], 128'h0);
            chk("rst_last",  out_last[d],  1'b0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Known-answer vectors, PIPE_STAGES=1, latency 1.
        in_valid[0] = 1'b1; in_state[0] = c_V_IN; in_last[0] = 1'b0;
        tick();
        in_valid[0] = 1'b0;
        chk("kat_mc_valid", out_valid[0], 1'b1);
        chk("kat_mc_state", out_state[0], c_V_MC);
        chk("kat_mc_last",  out_last[0],  1'b0);
        tick();
        in_valid[0] = 1'b1; in_last[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        chk("kat_sr_valid", out_valid[0], 1'b1);
        chk("kat_sr_state", out_state[0], c_V_SR);
        chk("kat_sr_last",  out_last[0],  1'b1);
        tick();

        // PIPE_STAGES=2: nothing after one edge, result after two.
        in_valid[1] = 1'b1; in_state[1] = c_V_IN; in_last[1] = 1'b0;
        tick();
        in_valid[1] = 1'b0;
        chk("p2_lat1_valid", out_valid[1], 1'b0);
        tick();
        chk("p2_lat2_valid", out_valid[1], 1'b1);
        chk("p2_lat2_state", out_state[1], c_V_MC);
        tick();

        // Three back-to-back operands against a 4-cycle downstream stall.
        stream(0, 3, 100, 100, 4, 1'b0, used);
        stream(1, 3, 100, 100, 4, 1'b0, used);

        // Reset while holding valid output.
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b1;
            in_state[d]  = rnd();
            in_last[d]   = ($urandom_range(1) != 0);
            out_ready[d] = 1'b0;
        end
        tick();
        for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) chk("prerst_valid", out_valid[d], 1'b1);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("midrst_valid", out_valid[d], 1'b0);
            chk("midrst_state", out_state[d], 128'h0);
            chk("midrst_last",  out_last[d],  1'b0);
            hold_v[d] = 1'b0;
        end
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int d = 0; d < 2; d++) out_ready[d] = 1'b1;
        repeat (4) tick();

        // Full throughput: one result per cycle after the pipeline latency.
        lat_chk = 1'b1;
        stream(1, 24, 100, 100, 0, 1'b0, used);
        chk("p2_throughput_cycles", used, 24 + 2);
        stream(0, 24, 100, 100, 0, 1'b0, used);
        chk("p1_throughput_cycles", used, 24 + 1);
        lat_chk = 1'b0;

`ifdef SHIFT_MIX_INV_EN
        in_valid[0] = 1'b1; in_inv[0] = 1'b1; in_state[0] = c_V_MC; in_last[0] = 1'b0;
        tick();
        in_valid[0] = 1'b0;
        in_inv[0]   = 1'b0;
        chk("kat_inv_state", out_state[0], c_V_IN);
        tick();
`endif

        // Randomized traffic with random backpressure and mixed flags.
        stream(0, 80, 70, 60, 0, c_INV_EN, used);
        stream(1, 80, 70, 60, 0, c_INV_EN, used);
        stream(0, 40, 100, 40, 0, c_INV_EN, used);
        stream(1, 40, 100, 40, 0, c_INV_EN, used);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_shift_mix_stage
`default_nettype wire

// File: doc/shift_mix_stage.md
SHIFT_MIX_STAGE -- requirements
Module: shift_mix_stage

Interface
REQ-001 The block SHALL have parameter PIPE_STAGES, default 1, meaning the number of register stages (legal values 1 or 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_state is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the stage accepts in_state this cycle.
REQ-006 The block SHALL have port in_state, input, 128 bits: the SubBytes output state.
REQ-007 The block SHALL have port in_last, input, 1 bit: final round, so MixColumns is skipped.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_state is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream stage (AddRoundKey) accepts.
REQ-010 The block SHALL have port out_state, output, 128 bits: the transformed state.
REQ-011 The block SHALL have port out_last, output, 1 bit: in_last delayed alongside its state.

Function
REQ-012 Byte order SHALL be FIPS-197 column-major: in_state[127:120] = s(0,0), [119:112] = s(1,0), ..., [7:0] = s(3,3).
REQ-013 ShiftRows SHALL rotate row r left by r byte positions, for r = 0..3.
REQ-014 MixColumns SHALL multiply each column by the matrix {02 03 01 01} in GF(2^8) with polynomial 0x11B; xtime SHALL be the left shift XOR 0x1B when bit 7 is set.
REQ-015 With in_last = 0 the output SHALL be MixColumns(ShiftRows(in_state)); with in_last = 1 it SHALL be ShiftRows(in_state).
REQ-016 A transfer SHALL occur on a rising edge where valid and ready are both 1, on either side.
REQ-017 With PIPE_STAGES = 1: output register after MixColumns, latency 1 cycle from accepted input to out_valid.
REQ-018 With PIPE_STAGES = 2: an additional register between ShiftRows and MixColumns, latency 2 cycles.
REQ-019 Each stage SHALL hold a valid bit; a stage SHALL be ready when it is empty or the next stage is ready; in_ready SHALL be the ready of the first stage.
REQ-020 While out_valid = 1 and out_ready = 0, out_state and out_last SHALL stay stable, and no accepted data SHALL be lost or duplicated.
REQ-021 When the stage is full and out_ready = 1 on the same edge as an input transfer, it SHALL emit the old data and load the new data, giving 1 transfer per cycle at full throughput.
REQ-022 in_ready SHALL NOT depend combinationally on in_valid.
REQ-023 Back-to-back operands with mixed in_last values SHALL each be processed according to their own flag.

Reset
REQ-024 On rst_n = 0 all valid bits, out_valid and out_last SHALL clear to 0 and out_state SHALL be 128'h0, asynchronously.
REQ-025 in_ready SHALL be 1 after reset is released.
REQ-026 Reset mid-operation SHALL discard all in-flight states, with no output after release until new input arrives.
REQ-027 Release of reset SHALL be synchronised externally.

Configuration
REQ-028 Macro SHIFT_MIX_INV_EN, when defined, SHALL add input port in_inv (1 bit, carried with the data).
REQ-029 With in_inv = 1 the output SHALL be InvShiftRows(InvMixColumns(in_state)), where InvMixColumns uses the matrix {0e 0b 0d 09} and InvShiftRows rotates row r right by r; in_last = 1 skips InvMixColumns.
REQ-030 Without SHIFT_MIX_INV_EN, the in_inv port and the inverse logic SHALL be absent, with forward operation only.

Structure
REQ-031 Package aes_pkg SHALL hold the state width (128), byte width, reduction constant 8'h1B, and the xtime/gmul function definitions.
REQ-032 Sub-module mix_single_column SHALL handle one 32-bit column, forward (and inverse when enabled); it SHALL be instantiated 4 times.

Verification
REQ-033 Directed test: in_state = d42711aee0bf98f1b8b45de51e415230, in_last = 0 -> out_state = 046681e5e0cb199a48f8d37a2806264c after 1 cycle (PIPE_STAGES = 1).
REQ-034 Directed test: the same input with in_last = 1 -> out_state = d4bf5d30e0b452aeb84111f11e2798e5 and out_last = 1.
REQ-035 Directed test: 3 back-to-back inputs with out_ready held at 0 for 4 cycles, then 1 -> outputs in order, no loss, out_state stable while stalled, in_ready = 0 once full.
REQ-036 Directed test: rst_n pulsed low while out_valid = 1 -> out_valid = 0 and out_state = 0 immediately; no stale output after release.
REQ-037 Directed test (SHIFT_MIX_INV_EN): in_inv = 1, in_state = 046681e5e0cb199a48f8d37a2806264c -> out_state = d42711aee0bf98f1b8b45de51e415230.
REQ-038 Directed test: PIPE_STAGES = 2 with continuous valid and ready -> 1 output per cycle after 2-cycle latency, matching a reference model.
